fft_frame_feeder: RTL and testbench

- Transmit-side framer for the 16-point `dit` FFT input interface. Accepts a free-running stream of 12-bit real samples and buffers them into N-sample frames in a ping-pong store.
- Drives each complete frame into the FFT as N back-to-back words on `fft_x`/`fft_nd`. Real part goes in the 12 MSBs; the imaginary 12 LSBs are zero.
- Waits for the FFT's result burst on `fft_out_nd` to finish before sending the next frame.
- Sits between the ADC capture logic and `dit`.

---
 rtl/fft_frame_feeder_if.sv | 23 ++
 rtl/fft_frame_feeder.sv | 136 +++++++++++++
 tb/tb_fft_frame_feeder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_feeder_if.sv
// Sample-stream and FFT-input bus for fft_frame_feeder.
// master: the feeder (consumes samples and FFT status, drives FFT input words).
// slave:  the environment (ADC capture on one side, the dit FFT on the other).
interface fft_frame_feeder_if #(
  parameter int DW = 12
);
  logic [DW-1:0]   smp_in;
  logic            smp_valid;
  logic [2*DW-1:0] fft_x;
  logic            fft_nd;
  logic            fft_out_nd;
  logic            fft_overflow;

  modport master (
    input  smp_in, smp_valid, fft_out_nd, fft_overflow,
    output fft_x, fft_nd
  );

  modport slave (
    output smp_in, smp_valid, fft_out_nd, fft_overflow,
    input  fft_x, fft_nd
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Ping-pong framer feeding N-sample real frames into the dit FFT.
// The writer fills one bank while the reader bursts the other bank as N
// back-to-back words, then waits for the FFT result burst to finish.
// Optional macro FFT_FEEDER_BITREV_EN: words leave in bit-reversed index order
// (DIT input order); without it they leave in natural order. Timing is the same.
module fft_frame_feeder #(
  parameter int N    = 16,
  parameter int LOGN = 4,
  parameter int DW   = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  fft_frame_feeder_if.master  bus,
  output logic                drop,
  output logic                fft_err,
  output logic [7:0]          frame_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  // Read-side index mapping into a bank.
  function automatic logic [LOGN-1:0] order(input logic [LOGN-1:0] i);
    logic [LOGN-1:0] r;
`ifdef FFT_FEEDER_BITREV_EN
    for (int b = 0; b < LOGN; b++) r[b] = i[LOGN-1-b];
`else
    r = i;
`endif
    return r;
  endfunction

  logic [DW-1:0]   bank [0:1][0:N-1];
  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic            wb;
  logic            rb;
  logic [LOGN-1:0] widx;
  logic [LOGN-1:0] ridx;
  state_t          state;

  logic            wr_en;
  logic            wr_last;
  logic            rd_last;
  logic [DW-1:0]   rd_word;

  assign wr_en   = bus.smp_valid && !full[wb];
  assign wr_last = wr_en && (widx == LOGN'(N-1));
  assign rd_last = (state == SEND) && (ridx == LOGN'(N-1));
  // ridx is 0 in IDLE, so the same lookup serves the first word of a burst.
  assign rd_word = bank[rb][order(ridx)];

  // Sample storage.
  // NOTE: the banks are plain data storage with no reset; the full flags alone
  // say whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) bank[wb][widx] <= bus.smp_in;
  end

  // Full flags: writer sets on the last sample, reader clears on the last word.
  // NOTE: combinational blocks use blocking '=' with a default first, so the
  // result never depends on a previous value and no latch is inferred.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wb] = 1'b1;
    if (rd_last) full_nxt[rb] = 1'b0;
  end

  // Full flag register; a bank released on an edge is seen as empty only on
  // the following edge, so a sample on the release edge is dropped.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) full <= '0;
    else          full <= full_nxt;
  end

  // Writer: fill bank wb; discard and flag when it is still held by the reader.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb   <= 1'b0;
      widx <= '0;
      drop <= 1'b0;
    end else begin
      drop <= bus.smp_valid && full[wb];
      if (wr_en) begin
        widx <= widx + 1'b1;
        if (wr_last) wb <= ~wb;
      end
    end
  end

  // Reader FSM with registered FFT-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rb         <= 1'b0;
      ridx       <= '0;
      bus.fft_nd <= 1'b0;
      bus.fft_x  <= '0;
      frame_cnt  <= '0;
    end else begin
      bus.fft_nd <= 1'b0;
      bus.fft_x  <= '0;
      case (state)
        IDLE: begin
          if (full[rb] && !bus.fft_out_nd) begin
            bus.fft_nd <= 1'b1;
            bus.fft_x  <= {rd_word, {DW{1'b0}}};
            ridx       <= ridx + 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          bus.fft_nd <= 1'b1;
          bus.fft_x  <= {rd_word, {DW{1'b0}}};
          ridx       <= ridx + 1'b1;
          if (ridx == LOGN'(N-1)) begin
            rb        <= ~rb;
            frame_cnt <= frame_cnt + 8'd1;
            state     <= WAIT_HI;
          end
        end
        WAIT_HI: if (bus.fft_out_nd)  state <= WAIT_LO;
        WAIT_LO: if (!bus.fft_out_nd) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky FFT overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fft_err <= 1'b0;
    else          fft_err <= fft_err | bus.fft_overflow;
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder: expected FFT words are queued when a
// frame is driven (or when its burst is allowed) and compared as they appear.
module tb_fft_frame_feeder;
  localparam int N    = 16;
  localparam int LOGN = 4;
  localparam int DW   = 12;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       drop;
  logic       fft_err;
  logic [7:0] frame_cnt;

  fft_frame_feeder_if #(.DW(DW)) bus ();

  fft_frame_feeder #(.N(N), .LOGN(LOGN), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .drop      (drop),
    .fft_err   (fft_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int words_seen = 0;
  int drop_cnt   = 0;
  logic [2*DW-1:0] exp_q [$];
  logic [2*DW-1:0] mon_exp;
  logic [DW-1:0]   fr [N];
  logic [DW-1:0]   fa [N];
  logic [DW-1:0]   fb [N];
  int t1_vals [N] = '{0, 7, 70, 1, 100, 32, 70, 43, 0, 4, -70, -92, 87, -92, 64, -38};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ord(input int i);
    int r;
`ifdef FFT_FEEDER_BITREV_EN
    r = 0;
    for (int b = 0; b < LOGN; b++) r[b] = i[LOGN-1-b];
`else
    r = i;
`endif
    return r;
  endfunction

  task automatic push_frame(input logic [DW-1:0] f [N]);
    for (int i = 0; i < N; i++) exp_q.push_back({f[ord(i)], {DW{1'b0}}});
  endtask

  task automatic rand_frame(output logic [DW-1:0] f [N]);
    for (int i = 0; i < N; i++) f[i] = DW'($urandom);
  endtask

  task automatic drive_frame(input logic [DW-1:0] f [N]);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.smp_valid = 1'b1;
      bus.smp_in    = f[i];
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.smp_valid = 1'b0;
    bus.smp_in    = '0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // FFT result burst: out_nd high for two cycles, then low.
  task automatic pulse_out_nd();
    @(negedge clk);
    bus.fft_out_nd = 1'b1;
    repeat (2) @(negedge clk);
    bus.fft_out_nd = 1'b0;
    @(negedge clk);
  endtask

  // Output monitor: every burst word must be expected; idle fft_x must be 0.
  always @(negedge clk) begin
    if (reset_n) begin
      if (drop) drop_cnt++;
      if (bus.fft_nd) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_nd", 32'(bus.fft_x), 32'hDEAD_0000);
        end else begin
          mon_exp = exp_q.pop_front();
          check("fft_x", 32'(bus.fft_x), 32'(mon_exp));
        end
      end else begin
        check("fft_x_idle_zero", 32'(bus.fft_x), 32'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int c;
    bus.smp_in       = '0;
    bus.smp_valid    = 1'b0;
    bus.fft_out_nd   = 1'b0;
    bus.fft_overflow = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_fft_nd", 32'(bus.fft_nd), 32'd0);
    check("rst_fft_x", 32'(bus.fft_x), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_fft_err", 32'(fft_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    reset_n = 1'b1;

    // Known frame; first word two edges after the last sample.
    for (int i = 0; i < N; i++) fr[i] = DW'(t1_vals[i]);
    push_frame(fr);
    drive_frame(fr);
    @(negedge clk);
    bus.smp_valid = 1'b0;
    check("latency_edge1_nd", 32'(bus.fft_nd), 32'd0);
    @(negedge clk);
    check("latency_edge2_nd", 32'(bus.fft_nd), 32'd1);
    drain("drain_frame1");
    check("frame_cnt_1", 32'(frame_cnt), 32'd1);

    // Backpressure: out_nd held low, 48 samples; two frames buffered, 16 dropped.
    drop_cnt = 0;
    rand_frame(fa);
    rand_frame(fb);
    rand_frame(fr);
    drive_frame(fa);
    drive_frame(fb);
    drive_frame(fr);
    idle_in();
    repeat (60) @(negedge clk);
    check("drop_count", 32'(drop_cnt), 32'd16);
    check("frame_cnt_held", 32'(frame_cnt), 32'd1);
    push_frame(fa);
    pulse_out_nd();
    drain("drain_bp_a");
    check("frame_cnt_2", 32'(frame_cnt), 32'd2);
    push_frame(fb);
    pulse_out_nd();
    drain("drain_bp_b");
    check("frame_cnt_3", 32'(frame_cnt), 32'd3);
    pulse_out_nd();
    check("drop_count_after", 32'(drop_cnt), 32'd16);

    // Overflow is sticky.
    check("err_before", 32'(fft_err), 32'd0);
    @(negedge clk);
    bus.fft_overflow = 1'b1;
    @(negedge clk);
    bus.fft_overflow = 1'b0;
    check("err_set", 32'(fft_err), 32'd1);
    repeat (10) @(negedge clk);
    check("err_sticky", 32'(fft_err), 32'd1);

    // Reset in the middle of a burst.
    rand_frame(fr);
    push_frame(fr);
    base = words_seen;
    drive_frame(fr);
    idle_in();
    c = 0;
    while (words_seen < base + 5 && c < 60) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("reached_word5", 32'(words_seen - base), 32'd5);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_fft_nd", 32'(bus.fft_nd), 32'd0);
    check("midrst_fft_x", 32'(bus.fft_x), 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_fft_err", 32'(fft_err), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_no_resume", 32'(bus.fft_nd), 32'd0);
    rand_frame(fr);
    push_frame(fr);
    drive_frame(fr);
    idle_in();
    drain("drain_after_rst");
    check("frame_cnt_after_rst", 32'(frame_cnt), 32'd1);
    pulse_out_nd();

    // Wrap: 255 more frames bring the count from 1 back to 0.
    for (int f = 0; f < 255; f++) begin
      rand_frame(fr);
      push_frame(fr);
      drive_frame(fr);
      idle_in();
      drain("drain_wrap");
      pulse_out_nd();
      if (f == 126) check("frame_cnt_mid", 32'(frame_cnt), 32'd128);
    end
    check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
